orb_frame_reader: RTL

- Downstream consumer of the orbital word packer.
- Reads completed 12-bit telemetry words from the shared ping-pong frame RAM, prefixes each frame with a sync marker, and serialises the frame MSB-first at a programmable bit rate.
- Owns bank switching: drives SW (the packer's bank select) and the 6-bit frame cycle counter that gates the packer's slow-channel slots.

---
 rtl/orb_pkg.sv | 22 ++
 rtl/orb_bit_shifter.sv | 108 ++++++++++
 rtl/orb_frame_reader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/orb_pkg.sv
// Shared definitions for the orbital telemetry frame reader.
//
// Contents:
//   ORB_WORD_W, ORB_ADDR_W, ORB_CYCLE_W : default widths shared with the packer
//   ORB_SYNC_WORD                       : marker symbol sent ahead of every frame
//   reader_state_t                      : frame reader FSM states
package orb_pkg;

    localparam int ORB_WORD_W  = 12;
    localparam int ORB_ADDR_W  = 11;
    localparam int ORB_CYCLE_W = 6;

    localparam logic [ORB_WORD_W-1:0] ORB_SYNC_WORD = 12'hE2D;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_SYNC  = 2'd1,
        SHIFT_SYNC = 2'd2,
        SHIFT_DATA = 2'd3
    } reader_state_t;

endpackage

// File: rtl/orb_bit_shifter.sv
// Bit-rate prescaler and symbol shift register for the frame reader.
//
// Optional build macro: ORB_PARITY_EN
//   defined   : every symbol is followed by one odd-parity bit (13 bits/symbol)
//   undefined : 12 bits/symbol, no parity logic
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous reset, active-low
//   run       in   prescaler counts while high (reader not idle)
//   load      in   start a new sync symbol on the next clk (divCnt=0, top bit)
//   wordIn    in   RAM read data, captured at divCnt==1 of the symbol's last bit
//   sdataRaw  out  current serial bit (parity bit on the last slot when enabled)
//   bitStrobe out  high on the first clk of every bit
//   bit0Next  out  the next clk begins the symbol's last bit (prefetch point)
//   symEnd    out  this clk ends the symbol's last bit
module orb_bit_shifter
    import orb_pkg::*;
#(
    parameter int                 WORD_W    = ORB_WORD_W,
    parameter int                 BIT_DIV   = 4,
    parameter logic [WORD_W-1:0]  SYNC_WORD = ORB_SYNC_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load,
    input  logic [WORD_W-1:0] wordIn,
    output logic              sdataRaw,
    output logic              bitStrobe,
    output logic              bit0Next,
    output logic              symEnd
);

`ifdef ORB_PARITY_EN
    localparam int SYM_BITS = WORD_W + 1;
`else
    localparam int SYM_BITS = WORD_W;
`endif
    localparam int IDX_W = $clog2(SYM_BITS);
    localparam int DIV_W = $clog2(BIT_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(SYM_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_CAPTURE = DIV_W'(1);

    logic [DIV_W-1:0]  divCnt;
    logic [IDX_W-1:0]  bitIdx;
    logic [WORD_W-1:0] shiftReg;
    logic [WORD_W-1:0] nextWord;
    logic              bitEnd;
`ifdef ORB_PARITY_EN
    logic              parBit;
`endif

    assign bitEnd    = run && (divCnt == DIV_LAST);
    assign symEnd    = bitEnd && (bitIdx == '0);
    assign bit0Next  = bitEnd && (bitIdx == IDX_W'(1));
    assign bitStrobe = run && (divCnt == '0);

`ifdef ORB_PARITY_EN
    assign sdataRaw = (bitIdx == '0) ? parBit : shiftReg[WORD_W-1];
`else
    assign sdataRaw = shiftReg[WORD_W-1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            nextWord <= '0;
`ifdef ORB_PARITY_EN
            parBit   <= 1'b0;
`endif
        end else if (load) begin
            // Loading on entry means the LOAD_SYNC clk already shows sync bit 11,
            // so back-to-back frames have no idle slot between them.
            divCnt   <= '0;
            bitIdx   <= LAST_IDX;
            shiftReg <= SYNC_WORD;
`ifdef ORB_PARITY_EN
            parBit   <= ~^SYNC_WORD;
`endif
        end else if (run) begin
            if (divCnt == DIV_LAST) begin
                divCnt <= '0;
                if (bitIdx == '0) begin
                    bitIdx   <= LAST_IDX;
                    shiftReg <= nextWord;
`ifdef ORB_PARITY_EN
                    parBit   <= ~^nextWord;
`endif
                end else begin
                    bitIdx   <= bitIdx - IDX_W'(1);
                    shiftReg <= {shiftReg[WORD_W-2:0], 1'b0};
                end
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
            // Address was presented during divCnt==0, so data is valid now.
            if ((bitIdx == '0) && (divCnt == DIV_CAPTURE)) begin
                nextWord <= wordIn;
            end
        end
    end

endmodule

// File: rtl/orb_frame_reader.sv
// Orbital frame reader: reads completed telemetry words from the ping-pong
// frame RAM, prefixes each frame with a sync marker and serialises it MSB-first.
// Also owns bank switching (SW) and the frame cycle counter seen by the packer.
//
// Optional build macro: ORB_PARITY_EN (odd parity bit after every symbol).
//
// RAM interface: fixed latency, no handshake. rdAddr is held stable for the
// whole last bit of a symbol; rdData is valid exactly one clk after rdAddr.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   en         in   enable streaming; sampled only at frame boundaries
//   rdAddr     out  {~SW, word index} RAM read address
//   rdData     in   RAM read data
//   SW         out  bank select to packer; toggles once per frame
//   cycle      out  frame counter to packer, wraps 63->0
//   sdata      out  serial data, MSB first
//   bitStrobe  out  pulse on the first clk of every bit
//   frameStart out  pulse with the bitStrobe of sync bit 11
//   dbgState   out  current FSM state (reader_state_t encoding)
module orb_frame_reader
    import orb_pkg::*;
#(
    parameter int                ADDR_W      = ORB_ADDR_W,
    parameter int                WORD_W      = ORB_WORD_W,
    parameter int                FRAME_WORDS = 2048,
    parameter int                BIT_DIV     = 4,
    parameter logic [WORD_W-1:0] SYNC_WORD   = ORB_SYNC_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [ADDR_W:0]        rdAddr,
    input  logic [WORD_W-1:0]      rdData,
    output logic                   SW,
    output logic [ORB_CYCLE_W-1:0] cycle,
    output logic                   sdata,
    output logic                   bitStrobe,
    output logic                   frameStart,
    output logic [1:0]             dbgState
);

    reader_state_t     state;
    reader_state_t     nextState;
    logic [ADDR_W-1:0] wordIdx;
    logic              lastWord;
    logic              frameEnd;
    logic              run;
    logic              load;
    logic              shiftBit;
    logic              bit0Next;
    logic              symEnd;

    assign lastWord   = (wordIdx == ADDR_W'(FRAME_WORDS - 1));
    assign run        = (state != IDLE);
    assign load       = (nextState == LOAD_SYNC);
    assign frameStart = (state == LOAD_SYNC);
    assign sdata      = run ? shiftBit : 1'b0;
    assign dbgState   = state;

    orb_bit_shifter #(
        .WORD_W    (WORD_W),
        .BIT_DIV   (BIT_DIV),
        .SYNC_WORD (SYNC_WORD)
    ) uShifter (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .load      (load),
        .wordIn    (rdData),
        .sdataRaw  (shiftBit),
        .bitStrobe (bitStrobe),
        .bit0Next  (bit0Next),
        .symEnd    (symEnd)
    );

    always_comb begin
        nextState = state;
        frameEnd  = 1'b0;
        case (state)
            IDLE:       if (en) nextState = LOAD_SYNC;
            LOAD_SYNC:  nextState = SHIFT_SYNC;
            SHIFT_SYNC: if (symEnd) nextState = SHIFT_DATA;
            SHIFT_DATA: begin
                if (symEnd && lastWord) begin
                    frameEnd  = 1'b1;
                    nextState = en ? LOAD_SYNC : IDLE;
                end
            end
            default:    nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wordIdx <= '0;
            rdAddr  <= '0;
            SW      <= 1'b0;
            cycle   <= '0;
        end else begin
            state <= nextState;

            if (state == LOAD_SYNC) begin
                wordIdx <= '0;
            end else if ((state == SHIFT_DATA) && symEnd && !lastWord) begin
                wordIdx <= wordIdx + ADDR_W'(1);
            end

            // Prefetch the following word; the last data word has no successor
            // in this frame, so the index never runs past FRAME_WORDS-1.
            if (bit0Next) begin
                if (state == SHIFT_SYNC) begin
                    rdAddr <= {~SW, {ADDR_W{1'b0}}};
                end else if ((state == SHIFT_DATA) && !lastWord) begin
                    rdAddr <= {~SW, wordIdx + ADDR_W'(1)};
                end
            end

            if (frameEnd) begin
                SW    <= ~SW;
                cycle <= cycle + ORB_CYCLE_W'(1);
            end
        end
    end

endmodule
